// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipelined control unit: opcodes, selector enums,
// the decoded control bundle and the per-stage register payloads.
package pipe_ctrl_pkg;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned IMM_W = 3;
    localparam int unsigned RES_W = 2;
    localparam int unsigned AOP_W = 2;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_IALU   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

    localparam logic [AOP_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [AOP_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [AOP_W-1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [IMM_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_e;

    typedef enum logic [RES_W-1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_IMM = 2'd3
    } result_src_e;

    // Full decoded bundle as produced in Decode
    typedef struct packed {
        logic              reg_write;
        imm_src_e          imm_src;
        logic              alu_src_a;
        logic              alu_src_b;
        logic              dmem_write;
        result_src_e       result_src;
        logic              branch;
        logic              jump;
        logic              jalr;
        logic [AOP_W-1:0]  alu_op;
        logic              illegal;
    } ctrl_t;

    // Stage payloads keep only what that stage or a later one consumes
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              alu_src_a;
        logic              alu_src_b;
        logic              dmem_write;
        result_src_e       result_src;
        logic              branch;
        logic              jump;
        logic              jalr;
        logic [AOP_W-1:0]  alu_op;
        logic              illegal;
    } e_ctrl_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              dmem_write;
        result_src_e       result_src;
        logic              illegal;
    } m_ctrl_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        result_src_e       result_src;
        logic              illegal;
    } w_ctrl_t;

    localparam e_ctrl_t BUBBLE   = '0;
    localparam m_ctrl_t BUBBLE_M = '0;
    localparam w_ctrl_t BUBBLE_W = '0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control-unit bus: Decode opcode and hazard inputs in, per-stage controls out.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [OP_W-1:0]  op_d;
    logic             stall_e;
    logic             flush_e;
    logic             zero_e;
    logic [IMM_W-1:0] imm_src_d;
    logic             illegal_d;
    logic             alu_src_a_e;
    logic             alu_src_b_e;
    logic [AOP_W-1:0] alu_op_e;
    logic             jalr_e;
    logic             pc_src_e;
    logic             load_e;
    logic             dmem_write_m;
    logic             reg_write_m;
    logic [RES_W-1:0] result_src_w;
    logic             reg_write_w;
    logic             illegal_w;

    modport slave (
        input  op_d, stall_e, flush_e, zero_e,
        output imm_src_d, illegal_d, alu_src_a_e, alu_src_b_e, alu_op_e,
               jalr_e, pc_src_e, load_e, dmem_write_m, reg_write_m,
               result_src_w, reg_write_w, illegal_w
    );

    modport master (
        output op_d, stall_e, flush_e, zero_e,
        input  imm_src_d, illegal_d, alu_src_a_e, alu_src_b_e, alu_op_e,
               jalr_e, pc_src_e, load_e, dmem_write_m, reg_write_m,
               result_src_w, reg_write_w, illegal_w
    );

endinterface

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode to control-bundle decoder; EXT_OPS gates jalr/lui/auipc.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter bit EXT_OPS = 1'b1
) (
    input  logic [OP_W-1:0] op_i,
    output ctrl_t           ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (op_i)
            OP_LOAD: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src_b  = 1'b1;
                ctrl_o.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctrl_o.imm_src    = IMM_S;
                ctrl_o.alu_src_b  = 1'b1;
                ctrl_o.dmem_write = 1'b1;
            end
            OP_RTYPE: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_op     = ALU_FUNCT;
            end
            OP_BRANCH: begin
                ctrl_o.imm_src    = IMM_B;
                ctrl_o.branch     = 1'b1;
                ctrl_o.alu_op     = ALU_SUB;
            end
            OP_IALU: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src_b  = 1'b1;
                ctrl_o.alu_op     = ALU_FUNCT;
            end
            OP_JAL: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.imm_src    = IMM_J;
                ctrl_o.jump       = 1'b1;
                ctrl_o.result_src = RES_PC4;
            end
            OP_JALR: begin
                if (EXT_OPS) begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.alu_src_b  = 1'b1;
                    ctrl_o.jump       = 1'b1;
                    ctrl_o.jalr       = 1'b1;
                    ctrl_o.result_src = RES_PC4;
                end else begin
                    ctrl_o.illegal    = 1'b1;
                end
            end
            OP_LUI: begin
                if (EXT_OPS) begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.imm_src    = IMM_U;
                    ctrl_o.result_src = RES_IMM;
                end else begin
                    ctrl_o.illegal    = 1'b1;
                end
            end
            OP_AUIPC: begin
                if (EXT_OPS) begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.imm_src    = IMM_U;
                    ctrl_o.alu_src_a  = 1'b1;
                    ctrl_o.alu_src_b  = 1'b1;
                end else begin
                    ctrl_o.illegal    = 1'b1;
                end
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: decodes in D and carries the bundle through E, M, W
// with bubble (flush) and hold (stall) support on the D->E register.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit EXT_OPS      = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    pipe_ctrl_if.slave  bus
);

    ctrl_t   dec;
    e_ctrl_t e_q, e_d;
    m_ctrl_t m_q, m_d;
    w_ctrl_t w_q, w_d;

    ctrl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
        .op_i   (bus.op_d),
        .ctrl_o (dec)
    );

    // D->E next state: flush beats stall, stall holds
    always_comb begin
        e_d = e_q;
        if (bus.flush_e) begin
            e_d = BUBBLE;
        end else if (!bus.stall_e) begin
            e_d = '{valid:      1'b1,
                    reg_write:  dec.reg_write,
                    alu_src_a:  dec.alu_src_a,
                    alu_src_b:  dec.alu_src_b,
                    dmem_write: dec.dmem_write,
                    result_src: dec.result_src,
                    branch:     dec.branch,
                    jump:       dec.jump,
                    jalr:       dec.jalr,
                    alu_op:     dec.alu_op,
                    illegal:    dec.illegal};
        end
    end

    always_comb begin
        m_d = '{valid:      e_q.valid,
                reg_write:  e_q.reg_write,
                dmem_write: e_q.dmem_write,
                result_src: e_q.result_src,
                illegal:    e_q.illegal};
        w_d = '{valid:      m_q.valid,
                reg_write:  m_q.reg_write,
                result_src: m_q.result_src,
                illegal:    m_q.illegal};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= BUBBLE;
            m_q <= BUBBLE_M;
            w_q <= BUBBLE_W;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign bus.imm_src_d    = dec.imm_src;
    assign bus.illegal_d    = dec.illegal;

    assign bus.alu_src_a_e  = e_q.valid & e_q.alu_src_a;
    assign bus.alu_src_b_e  = e_q.valid & e_q.alu_src_b;
    assign bus.alu_op_e     = e_q.valid ? e_q.alu_op : ALU_ADD;
    assign bus.jalr_e       = e_q.valid & e_q.jalr;
    assign bus.pc_src_e     = e_q.valid & ((e_q.branch & bus.zero_e) | e_q.jump);
    assign bus.load_e       = e_q.valid & (e_q.result_src == RES_MEM);

    assign bus.dmem_write_m = m_q.valid & m_q.dmem_write;
    assign bus.reg_write_m  = m_q.valid & m_q.reg_write;

    assign bus.result_src_w = w_q.valid ? w_q.result_src : RES_ALU;
    assign bus.reg_write_w  = w_q.valid & w_q.reg_write;
    assign bus.illegal_w    = ILLEGAL_TRAP & w_q.valid & w_q.illegal;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl: two instances (EXT_OPS=1 and EXT_OPS=0)
// compared each cycle against an opcode-tracking pipeline model.
module tb_pipe_ctrl;

    logic clk;
    logic reset;

    pipe_ctrl_if bus1 ();
    pipe_ctrl_if bus0 ();

    pipe_ctrl #(.EXT_OPS(1'b1), .ILLEGAL_TRAP(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    pipe_ctrl #(.EXT_OPS(1'b0), .ILLEGAL_TRAP(1'b1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rw;
        bit [2:0] imm;
        bit       sa;
        bit       sb;
        bit       dw;
        bit [1:0] rs;
        bit       br;
        bit       jp;
        bit       jr;
        bit [1:0] aop;
        bit       ill;
    } exp_t;

    int n_vec = 0;
    int n_err = 0;

    // In-flight opcodes per stage, plus the stage valid bits
    bit       e_v, m_v, w_v;
    bit [6:0] e_op, m_op, w_op;
    bit       armed;

    bit [6:0] legal_ops [9];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t expect_of(input bit [6:0] op, input bit ext);
        exp_t x;
        x = '{default: 0};
        case (op)
            7'b0000011: begin x.rw = 1; x.imm = 0; x.sb = 1; x.rs = 1; end
            7'b0100011: begin x.imm = 1; x.sb = 1; x.dw = 1; end
            7'b0110011: begin x.rw = 1; x.aop = 2; end
            7'b1100011: begin x.imm = 2; x.br = 1; x.aop = 1; end
            7'b0010011: begin x.rw = 1; x.sb = 1; x.aop = 2; end
            7'b1101111: begin x.rw = 1; x.imm = 3; x.jp = 1; x.rs = 2; end
            7'b1100111: begin
                if (ext) begin x.rw = 1; x.sb = 1; x.jp = 1; x.jr = 1; x.rs = 2; end
                else x.ill = 1;
            end
            7'b0110111: begin
                if (ext) begin x.rw = 1; x.imm = 4; x.rs = 3; end
                else x.ill = 1;
            end
            7'b0010111: begin
                if (ext) begin x.rw = 1; x.imm = 4; x.sa = 1; x.sb = 1; end
                else x.ill = 1;
            end
            default: x.ill = 1;
        endcase
        return x;
    endfunction

    task automatic check_dut(
        input string id, input bit ext, input bit [6:0] op, input bit zero,
        input logic [2:0] imm_d, input logic ill_d,
        input logic sa, input logic sb, input logic [1:0] aop, input logic jr,
        input logic pc, input logic ld, input logic dw_m, input logic rw_m,
        input logic [1:0] rs_w, input logic rw_w, input logic ill_w);
        exp_t xd, xe, xm, xw;
        xd = expect_of(op, ext);
        xe = e_v ? expect_of(e_op, ext) : '{default: 0};
        xm = m_v ? expect_of(m_op, ext) : '{default: 0};
        xw = w_v ? expect_of(w_op, ext) : '{default: 0};
        check({id, ".imm_src_d"},    32'(imm_d), 32'(xd.imm));
        check({id, ".illegal_d"},    32'(ill_d), 32'(xd.ill));
        check({id, ".alu_src_a_e"},  32'(sa),    32'(xe.sa));
        check({id, ".alu_src_b_e"},  32'(sb),    32'(xe.sb));
        check({id, ".alu_op_e"},     32'(aop),   32'(xe.aop));
        check({id, ".jalr_e"},       32'(jr),    32'(xe.jr));
        check({id, ".pc_src_e"},     32'(pc),    32'((xe.br & zero) | xe.jp));
        check({id, ".load_e"},       32'(ld),    32'(e_v && e_op == 7'b0000011));
        check({id, ".dmem_write_m"}, 32'(dw_m),  32'(xm.dw));
        check({id, ".reg_write_m"},  32'(rw_m),  32'(xm.rw));
        check({id, ".result_src_w"}, 32'(rs_w),  32'(xw.rs));
        check({id, ".reg_write_w"},  32'(rw_w),  32'(xw.rw));
        check({id, ".illegal_w"},    32'(ill_w), 32'(xw.ill));
    endtask

    // One cycle: drive inputs, check at negedge, advance the model at posedge
    task automatic step(input bit [6:0] op, input bit st, input bit fl,
                        input bit z, input bit rst);
        bus1.op_d = op;  bus1.stall_e = st; bus1.flush_e = fl; bus1.zero_e = z;
        bus0.op_d = op;  bus0.stall_e = st; bus0.flush_e = fl; bus0.zero_e = z;
        reset = rst;
        @(negedge clk);
        if (armed) begin
            check_dut("ext1", 1'b1, op, z,
                      bus1.imm_src_d, bus1.illegal_d, bus1.alu_src_a_e, bus1.alu_src_b_e,
                      bus1.alu_op_e, bus1.jalr_e, bus1.pc_src_e, bus1.load_e,
                      bus1.dmem_write_m, bus1.reg_write_m, bus1.result_src_w,
                      bus1.reg_write_w, bus1.illegal_w);
            check_dut("ext0", 1'b0, op, z,
                      bus0.imm_src_d, bus0.illegal_d, bus0.alu_src_a_e, bus0.alu_src_b_e,
                      bus0.alu_op_e, bus0.jalr_e, bus0.pc_src_e, bus0.load_e,
                      bus0.dmem_write_m, bus0.reg_write_m, bus0.result_src_w,
                      bus0.reg_write_w, bus0.illegal_w);
        end
        @(posedge clk);
        if (rst) begin
            e_v = 0; m_v = 0; w_v = 0;
            armed = 1;
        end else begin
            w_v = m_v; w_op = m_op;
            m_v = e_v; m_op = e_op;
            if (fl) e_v = 0;
            else if (!st) begin e_v = 1; e_op = op; end
        end
        #1;
    endtask

    localparam bit [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         BEQ = 7'b1100011, IALU = 7'b0010011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    initial begin
        bit [6:0] op;
        legal_ops = '{LW, SW, RT, BEQ, IALU, JAL, JALR, LUI, AUIPC};
        armed = 0;
        e_v = 0; m_v = 0; w_v = 0;
        e_op = 0; m_op = 0; w_op = 0;

        step(RT, 0, 0, 0, 1);
        step(RT, 0, 0, 0, 1);
        // lw through all stages
        step(LW, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);
        // beq with zero high, then low
        step(BEQ, 0, 0, 0, 0);
        step(RT, 0, 0, 1, 0);
        step(BEQ, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);
        // sw flushed, then flush together with stall
        step(SW, 0, 1, 0, 0);
        step(SW, 0, 0, 0, 0);
        step(SW, 1, 1, 0, 0);
        step(RT, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);
        // lui: legal on ext1, illegal on ext0
        step(LUI, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);
        // lw then jal, reset with jal in E and lw in M
        step(LW, 0, 0, 0, 0);
        step(JAL, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 1);
        step(RT, 0, 0, 0, 0);
        // back-to-back I-ALU, jalr, auipc
        step(IALU, 0, 0, 0, 0);
        step(JALR, 0, 0, 0, 0);
        step(AUIPC, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);
        step(RT, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) < 9) op = legal_ops[$urandom_range(0, 8)];
            else op = 7'($urandom);
            step(op, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                 1'($urandom), $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
